maze_explorer: RTL and testbench
================================

// Module: maze_explorer
// PURPOSE
//  Depth-first maze solver controller; sits directly upstream of the coordinate stack and drives its push/pop port.
//  Walks a 2^W x 2^W grid from (START_X,START_Y) to (GOAL_X,GOAL_Y), reading one wall bit per cycle from external maze memory.
//  Pushes each cell it leaves, pops on dead ends. On success the stack holds the path: top = last cell before goal.
// PARAMETERS
//  W          4    coordinate width per axis; grid is 2^W x 2^W
//  START_X/Y  0,0  start cell
//  GOAL_X/Y   15,15 goal cell
//  MAX_DEPTH  63   stack capacity; a push beyond it aborts with err
// PORTS
//  clk        in   1   clock
//  rst        in   1   asynchronous, active-high reset
//  start      in   1   begin run; sampled only in IDLE, DONE, FAIL
//  maze_x     out  W   maze memory read column
//  maze_y     out  W   maze memory read row
//  maze_wall  in   1   wall bit for (maze_x,maze_y), valid 1 cycle after address (1=wall)
//  stk_push   out  1   push pulse to stack
//  stk_pop    out  1   pop pulse to stack
//  stk_xo     out  W   x to stack xIn
//  stk_yo     out  W   y to stack yIn
//  stk_xi     in   W   stack xOut, valid the cycle after stk_pop
//  stk_yi     in   W   stack yOut, valid the cycle after stk_pop
//  stk_fail   in   1   stack underflow flag
//  busy       out  1   run in progress
//  done       out  1   goal reached; held until next start
//  no_path    out  1   search exhausted or start cell is a wall; held until next start
//  err        out  1   depth overflow or unexpected stk_fail; held until next start
//  cur_x/y    out  W   current cell
// BEHAVIOUR
//  Reset: every output 0; state IDLE; depth=0; visited map cleared.
//  States: IDLE, DRAIN, INIT, CHECK, EVAL, PUSH, POP, POPWAIT, DONE, FAIL.
//  start in IDLE/DONE/FAIL: clear visited (1 cycle), clear flags, busy=1.
//    If depth!=0, go to DRAIN; else go to INIT.
//  DRAIN: one stk_pop per cycle while depth>0 (depth--), then INIT; empties the previous run's path.
//  INIT: cur<=START; addr=START; next cycle wall=1 -> FAIL(no_path), else mark visited, dir=0 -> CHECK.
//  Dir order 0..3: +x, +y, -x, -y.
//  CHECK: neighbour out of bounds (no wrap) or visited -> dir++ in same cycle, no read issued.
//    Otherwise drive maze_x/y -> EVAL.
//  EVAL: wall=0 -> PUSH; wall=1 -> dir++, back to CHECK.
//  All 4 dirs exhausted: depth==0 -> FAIL(no_path); else -> POP.
//  PUSH: stk_push=1 with stk_xo/yo=cur; depth++; cur<=neighbour; mark visited; dir=0.
//    New cur==GOAL -> DONE, else CHECK.
//    depth==MAX_DEPTH before push -> FAIL(err), no push issued.
//  POP: stk_pop=1; depth-- -> POPWAIT.
//  POPWAIT: cur<={stk_xi,stk_yi}; dir=0 -> CHECK. Rescan is cheap because the visited map blocks loops.
//    stk_fail=1 here or in DRAIN -> FAIL(err).
//  START==GOAL: DONE immediately after INIT when the cell is free.
//  stk_push and stk_pop are never high together; each is a 1-cycle pulse.
//  start while busy is ignored. rst mid-run: immediate return to reset state, no further stack pulses.
//  Coordinate arithmetic is W-bit; bounds are tested on the carry/borrow, never on the wrapped value.
// CONFIGURATION
//  STEP_COUNT_EN defined: extra output steps[15:0], counting PUSH+POP events of the current run.
//    Saturates at 16'hFFFF; cleared on start and on rst.
//  STEP_COUNT_EN undefined: no steps port, no counter logic.
// STRUCTURE
//  Package maze_pkg: coordinate width W, dir_t (4-value enum), state_t enum, neighbour offset constants.
//  Sub-module maze_visited_map: 2^(2W)-bit flag array with single-cycle clear, 1 write port and 1 combinational read port.
// TESTING
//  Open 16x16 maze (all 0) -> done after 30 pushes, path along row 0 then column 15, depth=30, no_path=0.
//  Start cell wall -> no_path=1 two cycles after start; no stk_push/stk_pop ever asserted.
//  Goal walled in by (14,15) and (15,14) -> no_path=1; every push matched by a pop; depth=0 at end.
//  Dead-end corridor (0,0)->(3,0) closed -> 3 pops observed, search resumes down column 0; done=1.
//  Serpentine maze needing 64 cells on stack -> err=1, no 64th push.
//  rst mid-run, then start on a fresh stack -> clean run; restart after done -> DRAIN pops exactly depth entries first.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: shared types and constants for the depth-first maze explorer.
//   MAZE_W        default coordinate width per axis (grid is 2^W x 2^W)
//   dir_t         scan direction, tried in order +x, +y, -x, -y
//   state_t       controller states
//   OFF_*         two-bit signed neighbour offsets, used through dir_dx/dir_dy
package maze_pkg;

  localparam int MAZE_W = 4;

  typedef enum logic [1:0] {
    DIR_PX = 2'd0,
    DIR_PY = 2'd1,
    DIR_MX = 2'd2,
    DIR_MY = 2'd3
  } dir_t;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_DRAIN   = 4'd1,
    S_INIT    = 4'd2,
    S_CHECK   = 4'd3,
    S_EVAL    = 4'd4,
    S_PUSH    = 4'd5,
    S_POP     = 4'd6,
    S_POPWAIT = 4'd7,
    S_DONE    = 4'd8,
    S_FAIL    = 4'd9
  } state_t;

  localparam logic [1:0] OFF_POS  = 2'b01;
  localparam logic [1:0] OFF_ZERO = 2'b00;
  localparam logic [1:0] OFF_NEG  = 2'b11;

  function automatic logic [1:0] dir_dx(input dir_t d);
    case (d)
      DIR_PX:  dir_dx = OFF_POS;
      DIR_MX:  dir_dx = OFF_NEG;
      default: dir_dx = OFF_ZERO;
    endcase
  endfunction

  function automatic logic [1:0] dir_dy(input dir_t d);
    case (d)
      DIR_PY:  dir_dy = OFF_POS;
      DIR_MY:  dir_dy = OFF_NEG;
      default: dir_dy = OFF_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/maze_visited_map.sv
// maze_visited_map: one flag per grid cell, recording cells already entered.
//   clk, rst      clock, asynchronous active-high reset (clears all flags)
//   clr           synchronous clear of the whole map in one cycle (wins over we)
//   we, wx, wy    set the flag of cell (wx,wy)
//   rx, ry, hit   combinational read of the flag of cell (rx,ry)
module maze_visited_map
  import maze_pkg::*;
#(
  parameter int W = MAZE_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] wx,
  input  logic [W-1:0] wy,
  input  logic [W-1:0] rx,
  input  logic [W-1:0] ry,
  output logic         hit
);

  localparam int N = 1 << (2 * W);

  logic [N-1:0] flags;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else if (clr) begin
      flags <= '0;
    end else if (we) begin
      flags[{wy, wx}] <= 1'b1;
    end
  end

  assign hit = flags[{ry, rx}];

endmodule

// File: rtl/maze_explorer.sv
// maze_explorer: depth-first maze solver driving an external coordinate stack.
// Walks from (START_X,START_Y) to (GOAL_X,GOAL_Y) on a 2^W x 2^W grid, one wall
// read per probe. On success the stack holds the path, top = cell before goal.
// Optional build macro: STEP_COUNT_EN adds output steps[15:0] (PUSH+POP events
// of the current run, saturating); without it there is no steps port.
//   clk, rst             clock, asynchronous active-high reset
//   start                begin a run (honoured only in IDLE/DONE/FAIL)
//   maze_x/y, maze_wall  maze memory read address / wall bit one cycle later
//   stk_push/pop         one-cycle pulses to the stack, never together
//   stk_xo/yo            coordinate pushed; stk_xi/yi popped coordinate
//   stk_fail             stack underflow flag
//   busy, done, no_path, err   run status; flags held until the next start
//   cur_x/y              current cell
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | after reset, waiting for start
// S_DRAIN   | popping the previous run's path off the stack
// S_INIT    | reading the start cell's wall (address cycle, then data cycle)
// S_CHECK   | testing neighbour in dir for bounds/visited; issues wall read
// S_EVAL    | wall bit arrives; open -> push, wall -> next dir
// S_PUSH    | push pulse out; move into neighbour
// S_POP     | pop pulse out
// S_POPWAIT | popped coordinate arrives; becomes current cell
// S_DONE    | goal reached
// S_FAIL    | no path or error
module maze_explorer
  import maze_pkg::*;
#(
  parameter int W         = MAZE_W,
  parameter int START_X   = 0,
  parameter int START_Y   = 0,
  parameter int GOAL_X    = 15,
  parameter int GOAL_Y    = 15,
  parameter int MAX_DEPTH = 63
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [W-1:0] maze_x,
  output logic [W-1:0] maze_y,
  input  logic         maze_wall,
  output logic         stk_push,
  output logic         stk_pop,
  output logic [W-1:0] stk_xo,
  output logic [W-1:0] stk_yo,
  input  logic [W-1:0] stk_xi,
  input  logic [W-1:0] stk_yi,
  input  logic         stk_fail,
  output logic         busy,
  output logic         done,
  output logic         no_path,
  output logic         err,
  output logic [W-1:0] cur_x,
  output logic [W-1:0] cur_y
`ifdef STEP_COUNT_EN
  ,
  output logic [15:0]  steps
`endif
);

  localparam int DW = $clog2(MAX_DEPTH + 1);
  localparam logic [W-1:0]  SX   = W'(START_X);
  localparam logic [W-1:0]  SY   = W'(START_Y);
  localparam logic [W-1:0]  GX   = W'(GOAL_X);
  localparam logic [W-1:0]  GY   = W'(GOAL_Y);
  localparam logic [DW-1:0] DMAX = DW'(MAX_DEPTH);

  state_t        state;
  dir_t          dir;
  logic [DW-1:0] depth;
  logic          init_rd;
  logic          vis_clr;

  logic [1:0]    dx;
  logic [1:0]    dy;
  logic [W:0]    nx_ext;
  logic [W:0]    ny_ext;
  logic [W-1:0]  nb_x;
  logic [W-1:0]  nb_y;
  logic          nb_oob;
  logic          vis_we;
  logic [W-1:0]  vis_wx;
  logic [W-1:0]  vis_wy;
  logic          vis_hit;
  logic          blocked;

  // Neighbour computed one bit wider; the top bit is the carry (x=max, +1)
  // or borrow (x=0, -1), so out-of-bounds never aliases to a wrapped cell.
  assign dx     = dir_dx(dir);
  assign dy     = dir_dy(dir);
  assign nx_ext = {1'b0, cur_x} + {{(W-1){dx[1]}}, dx};
  assign ny_ext = {1'b0, cur_y} + {{(W-1){dy[1]}}, dy};
  assign nb_x   = nx_ext[W-1:0];
  assign nb_y   = ny_ext[W-1:0];
  assign nb_oob = nx_ext[W] | ny_ext[W];

  // Read address is combinational so the wall bit lands in the very next state.
  assign maze_x = (state == S_INIT) ? cur_x : nb_x;
  assign maze_y = (state == S_INIT) ? cur_y : nb_y;

  assign vis_we = (state == S_PUSH) || ((state == S_INIT) && init_rd && !maze_wall);
  assign vis_wx = (state == S_PUSH) ? nb_x : cur_x;
  assign vis_wy = (state == S_PUSH) ? nb_y : cur_y;

  // In CHECK the probe is blocked by bounds/visited; in EVAL by the wall bit.
  assign blocked = (state == S_CHECK) ? (nb_oob | vis_hit) : maze_wall;

  maze_visited_map #(.W(W)) u_visited (
    .clk (clk),
    .rst (rst),
    .clr (vis_clr),
    .we  (vis_we),
    .wx  (vis_wx),
    .wy  (vis_wy),
    .rx  (nb_x),
    .ry  (nb_y),
    .hit (vis_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      dir      <= DIR_PX;
      depth    <= '0;
      init_rd  <= 1'b0;
      vis_clr  <= 1'b0;
      cur_x    <= '0;
      cur_y    <= '0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      stk_xo   <= '0;
      stk_yo   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      no_path  <= 1'b0;
      err      <= 1'b0;
    end else begin
      vis_clr  <= 1'b0;
      stk_push <= 1'b0;
      stk_pop  <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_FAIL: begin
          if (start) begin
            vis_clr <= 1'b1;
            busy    <= 1'b1;
            done    <= 1'b0;
            no_path <= 1'b0;
            err     <= 1'b0;
            cur_x   <= SX;
            cur_y   <= SY;
            dir     <= DIR_PX;
            init_rd <= 1'b0;
            state   <= (depth != '0) ? S_DRAIN : S_INIT;
          end
        end
        S_DRAIN: begin
          // Leave only after the last pop's stk_fail has had a cycle to show.
          if (stk_fail) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_FAIL;
          end else if (depth != '0) begin
            stk_pop <= 1'b1;
            depth   <= depth - DW'(1);
          end else if (!stk_pop) begin
            state <= S_INIT;
          end
        end
        S_INIT: begin
          if (!init_rd) begin
            init_rd <= 1'b1;
          end else begin
            init_rd <= 1'b0;
            if (maze_wall) begin
              no_path <= 1'b1;
              busy    <= 1'b0;
              state   <= S_FAIL;
            end else if (cur_x == GX && cur_y == GY) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              dir   <= DIR_PX;
              state <= S_CHECK;
            end
          end
        end
        S_CHECK, S_EVAL: begin
          if (blocked) begin
            state <= S_CHECK;
            if (dir != DIR_MY) begin
              dir <= dir_t'(dir + 2'd1);
            end else if (depth == '0) begin
              no_path <= 1'b1;
              busy    <= 1'b0;
              state   <= S_FAIL;
            end else begin
              stk_pop <= 1'b1;
              state   <= S_POP;
            end
          end else if (state == S_CHECK) begin
            state <= S_EVAL;
          end else if (depth == DMAX) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_FAIL;
          end else begin
            stk_push <= 1'b1;
            stk_xo   <= cur_x;
            stk_yo   <= cur_y;
            state    <= S_PUSH;
          end
        end
        S_PUSH: begin
          depth <= depth + DW'(1);
          cur_x <= nb_x;
          cur_y <= nb_y;
          dir   <= DIR_PX;
          if (nb_x == GX && nb_y == GY) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            state <= S_CHECK;
          end
        end
        S_POP: begin
          depth <= depth - DW'(1);
          state <= S_POPWAIT;
        end
        S_POPWAIT: begin
          if (stk_fail) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= S_FAIL;
          end else begin
            cur_x <= stk_xi;
            cur_y <= stk_yi;
            dir   <= DIR_PX;
            state <= S_CHECK;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef STEP_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      steps <= '0;
    end else if ((state == S_IDLE || state == S_DONE || state == S_FAIL) && start) begin
      steps <= '0;
    end else if ((state == S_PUSH || state == S_POP) && steps != 16'hFFFF) begin
      steps <= steps + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_maze_explorer.sv
// tb_maze_explorer: directed and random mazes against a plain DFS reference.
// The bench supplies a registered maze memory and a queue-based stack.
module tb_maze_explorer;
  import maze_pkg::*;

  localparam int W = 4;
  localparam int MAXD = 63;
  localparam int R_DONE = 0, R_NOPATH = 1, R_ERR = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [W-1:0] maze_x, maze_y, stk_xo, stk_yo, cur_x, cur_y;
  logic [W-1:0] stk_xi = '0, stk_yi = '0;
  logic maze_wall = 1'b0;
  logic stk_fail = 1'b0;
  logic stk_push, stk_pop, busy, done, no_path, err;
`ifdef STEP_COUNT_EN
  logic [15:0] steps;
`endif

  always #5 clk = ~clk;

  maze_explorer #(.W(W), .START_X(0), .START_Y(0), .GOAL_X(15), .GOAL_Y(15), .MAX_DEPTH(MAXD)) dut (
    .clk(clk), .rst(rst), .start(start),
    .maze_x(maze_x), .maze_y(maze_y), .maze_wall(maze_wall),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_xo(stk_xo), .stk_yo(stk_yo),
    .stk_xi(stk_xi), .stk_yi(stk_yi), .stk_fail(stk_fail),
    .busy(busy), .done(done), .no_path(no_path), .err(err),
    .cur_x(cur_x), .cur_y(cur_y)
`ifdef STEP_COUNT_EN
    , .steps(steps)
`endif
  );

  bit wall_map [16][16];  // [y][x]
  always @(posedge clk) maze_wall <= wall_map[maze_y][maze_x];

  logic [7:0] stk_q[$];
  int n_push = 0, n_pop = 0, both_hi = 0, rst_pulses = 0;
  always @(posedge clk) begin
    if (rst) begin
      stk_q.delete();
      stk_fail <= 1'b0;
      if (stk_push || stk_pop) rst_pulses++;
    end else begin
      stk_fail <= 1'b0;
      if (stk_push && stk_pop) both_hi++;
      if (stk_push) begin
        stk_q.push_back({stk_xo, stk_yo});
        n_push++;
      end
      if (stk_pop) begin
        n_pop++;
        if (stk_q.size() == 0) stk_fail <= 1'b1;
        else {stk_xi, stk_yi} <= stk_q.pop_back();
      end
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: textbook DFS over the current wall_map.
  int m_res, m_push, m_pop, m_cx, m_cy;
  logic [7:0] m_stk[$];

  task automatic run_model();
    bit vis [16][16];
    int cx, cy, nx, ny, found, fin;
    int dxs[4];
    int dys[4];
    logic [7:0] e;
    dxs = '{1, 0, -1, 0};
    dys = '{0, 1, 0, -1};
    foreach (vis[i, j]) vis[i][j] = 1'b0;
    m_stk.delete();
    m_push = 0;
    m_pop = 0;
    cx = 0;
    cy = 0;
    fin = 0;
    if (wall_map[cy][cx]) begin
      m_res = R_NOPATH;
      fin = 1;
    end else begin
      vis[cy][cx] = 1'b1;
      if (cx == 15 && cy == 15) begin
        m_res = R_DONE;
        fin = 1;
      end
    end
    while (!fin) begin
      found = 0;
      nx = 0;
      ny = 0;
      for (int d = 0; d < 4; d++) begin
        if (!found) begin
          nx = cx + dxs[d];
          ny = cy + dys[d];
          if (nx >= 0 && nx < 16 && ny >= 0 && ny < 16)
            if (!vis[ny][nx] && !wall_map[ny][nx]) found = 1;
        end
      end
      if (found) begin
        if (m_stk.size() == MAXD) begin
          m_res = R_ERR;
          fin = 1;
        end else begin
          m_stk.push_back({cx[3:0], cy[3:0]});
          m_push++;
          cx = nx;
          cy = ny;
          vis[cy][cx] = 1'b1;
          if (cx == 15 && cy == 15) begin
            m_res = R_DONE;
            fin = 1;
          end
        end
      end else if (m_stk.size() == 0) begin
        m_res = R_NOPATH;
        fin = 1;
      end else begin
        e = m_stk.pop_back();
        m_pop++;
        cx = int'(e[7:4]);
        cy = int'(e[3:0]);
      end
    end
    m_cx = cx;
    m_cy = cy;
  endtask

  task automatic clear_maze();
    foreach (wall_map[i, j]) wall_map[i][j] = 1'b0;
  endtask

  task automatic do_run(input string tag, output int run_push, output int tot_pop);
    int p0, q0, prev_depth, cyc;
    prev_depth = stk_q.size();
    run_model();
    p0 = n_push;
    q0 = n_pop;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc = 0;
    while (busy && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_timeout"}, (cyc < 20000), 1);
    run_push = n_push - p0;
    tot_pop = n_pop - q0;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, (m_res == R_DONE));
    check({tag, "_nopath"}, no_path, (m_res == R_NOPATH));
    check({tag, "_err"}, err, (m_res == R_ERR));
    check({tag, "_pushes"}, run_push, m_push);
    check({tag, "_pops"}, tot_pop, prev_depth + m_pop);
    check({tag, "_curx"}, cur_x, m_cx);
    check({tag, "_cury"}, cur_y, m_cy);
    check({tag, "_depth"}, stk_q.size(), m_stk.size());
    if (stk_q.size() == m_stk.size())
      for (int i = 0; i < m_stk.size(); i++)
        check($sformatf("%s_stk%0d", tag, i), stk_q[i], m_stk[i]);
`ifdef STEP_COUNT_EN
    check({tag, "_steps"}, steps, m_push + m_pop);
`endif
  endtask

  initial begin
    int rp, tp, p0, q0;
    logic [7:0] top;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_nopath", no_path, 0);
    check("rst_err", err, 0);
    check("rst_push", stk_push, 0);
    check("rst_pop", stk_pop, 0);
    check("rst_cur", {cur_x, cur_y}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Start cell walled: no_path exactly two cycles after the start edge.
    clear_maze();
    wall_map[0][0] = 1'b1;
    p0 = n_push;
    q0 = n_pop;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("sw_busy", busy, 1);
    @(negedge clk);
    check("sw_np_c1", no_path, 0);
    @(negedge clk);
    check("sw_np_c2", no_path, 1);
    check("sw_busy_end", busy, 0);
    check("sw_pushes", n_push - p0, 0);
    check("sw_pops", n_pop - q0, 0);

    // Open maze.
    clear_maze();
    do_run("open", rp, tp);
    check("open_push30", rp, 30);
    top = (stk_q.size() > 0) ? stk_q[stk_q.size() - 1] : 8'h00;
    check("open_top", top, 8'hFE);
    check("open_done", done, 1);

    // Restart after done drains exactly the 30 entries first.
    do_run("redo", rp, tp);
    check("redo_drain", tp, 30);

    // Goal walled in, only row 0 and column 15 open.
    foreach (wall_map[i, j]) wall_map[i][j] = !(i == 0 || j == 15);
    wall_map[14][15] = 1'b1;
    do_run("gwall", rp, tp);
    check("gwall_nopath", no_path, 1);
    check("gwall_balance", tp - 30, rp);
    check("gwall_empty", stk_q.size(), 0);

    // Dead-end corridor (0,0)..(3,0).
    clear_maze();
    wall_map[0][4] = 1'b1;
    wall_map[1][1] = 1'b1;
    wall_map[1][2] = 1'b1;
    wall_map[1][3] = 1'b1;
    do_run("dead", rp, tp);
    check("dead_pops3", tp, 3);
    check("dead_done", done, 1);

    // Serpentine: depth overflows.
    foreach (wall_map[i, j])
      wall_map[i][j] = (i % 2 == 1) && !((i % 4 == 1 && j == 15) || (i % 4 == 3 && j == 0));
    do_run("serp", rp, tp);
    check("serp_err", err, 1);
    check("serp_push63", rp, 63);

    // Reset in the middle of a run.
    clear_maze();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pulse", {stk_push, stk_pop}, 0);
    check("mid_rst_cur", {cur_x, cur_y}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_run("after_rst", rp, tp);
    check("after_rst_done", done, 1);

    // Random mazes.
    for (int r = 0; r < 10; r++) begin
      int dens;
      dens = $urandom_range(10, 40);
      foreach (wall_map[i, j]) wall_map[i][j] = ($urandom_range(0, 99) < dens);
      if ($urandom_range(0, 7) != 0) wall_map[0][0] = 1'b0;
      do_run($sformatf("rnd%0d", r), rp, tp);
    end

    check("push_pop_overlap", both_hi, 0);
    check("pulses_in_rst", rst_pulses, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
